// File: rtl/seg_display_driver_if.sv
// Board-side signals of the seven-segment debug display driver: the debug words
// and word select coming in, the debounced step pulse and display drive going out.
interface seg_display_driver_if;
  logic [1:0]  sw_sel;
  logic [15:0] in_sign1;
  logic [15:0] in_sign2;
  logic [15:0] in_sign3;
  logic [15:0] in_sign4;
  logic        btn_step;
  logic        step_pulse;
  logic [3:0]  an;
  logic [7:0]  seg;

  modport master (
    output sw_sel, in_sign1, in_sign2, in_sign3, in_sign4, btn_step,
    input  step_pulse, an, seg
  );

  modport slave (
    input  sw_sel, in_sign1, in_sign2, in_sign3, in_sign4, btn_step,
    output step_pulse, an, seg
  );
endinterface

// File: rtl/seg_display_driver.sv
// Shows one selected 16-bit debug word as four hex digits on a multiplexed
// active-low seven-segment display, and debounces the step button into a pulse.
module seg_display_driver #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic                 CLK,
  input logic                 Reset,
  seg_display_driver_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} deb_state_t;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      snap_q, snap_d;
  logic             load_pending_q, load_pending_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [1:0]       sync_q, sync_d;
  deb_state_t       state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             step_pulse_q, step_pulse_d;

  logic        div_wrap;
  logic        btn_s;
  logic [15:0] sel_word;
  logic [3:0]  nibble;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      default: r = 7'h0E;
    endcase
    return r;
  endfunction

  always_comb begin
    case (bus.sw_sel)
      2'd0:    sel_word = bus.in_sign1;
      2'd1:    sel_word = bus.in_sign2;
      2'd2:    sel_word = bus.in_sign3;
      default: sel_word = bus.in_sign4;
    endcase

    div_wrap       = (div_cnt_q == DIV_LAST);
    div_cnt_d      = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    digit_d        = div_wrap ? digit_q + 2'd1 : digit_q;
    load_pending_d = 1'b0;

    // Capture only at frame start so all four digits come from one word.
    snap_d = (load_pending_q || (div_wrap && digit_q == 2'd3)) ? sel_word : snap_q;

    // Display regs follow the next digit/snapshot so they move with digit_q.
    nibble = snap_d[{digit_d, 2'b00} +: 4];
    an_d   = ~(4'b0001 << digit_d);
    seg_d  = {(digit_d != 2'd2), hex7(nibble)};
  end

  assign btn_s = sync_q[1];

  always_comb begin
    sync_d       = {sync_q[0], bus.btn_step};
    state_d      = state_q;
    deb_cnt_d    = deb_cnt_q;
    step_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d      = HELD;
          step_pulse_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end
      end
      default: begin
        // A bounce back high during release just returns to HELD: no new pulse.
        if (btn_s) begin
          state_d = HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      div_cnt_q      <= '0;
      digit_q        <= 2'd0;
      snap_q         <= 16'h0000;
      load_pending_q <= 1'b1;
      an_q           <= 4'b1111;
      seg_q          <= 8'hFF;
      sync_q         <= 2'b00;
      state_q        <= IDLE;
      deb_cnt_q      <= '0;
      step_pulse_q   <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      digit_q        <= digit_d;
      snap_q         <= snap_d;
      load_pending_q <= load_pending_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      sync_q         <= sync_d;
      state_q        <= state_d;
      deb_cnt_q      <= deb_cnt_d;
      step_pulse_q   <= step_pulse_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: fixed display vectors, hand-written
// debounce/reset sequences and a randomized run against a behavioural model.
module tb_seg_display_driver;
  localparam int SD    = 4;
  localparam int DEB   = 8;
  localparam int FRAME = 4 * SD;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  seg_display_driver_if bus();

  seg_display_driver #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] word;
    logic [7:0]  s0, s1, s2, s3;
  } vec_t;
  vec_t vecs [6];

  int errors = 0;
  int checks = 0;

  // Behavioural model: e = edges since reset release; debounced level flips
  // once the synchronised button has disagreed with it for DEB+1 samples.
  int          e;
  logic [15:0] m_snap;
  logic        m_deb;
  int          m_run;
  logic [1:0]  m_sq;
  logic        m_pulse;
  int          pulses;
  int          cyc = 0;
  int          last_pulse_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sel_word();
    case (bus.sw_sel)
      2'd0:    return bus.in_sign1;
      2'd1:    return bus.in_sign2;
      2'd2:    return bus.in_sign3;
      default: return bus.in_sign4;
    endcase
  endfunction

  function automatic logic [3:0] exp_an();
    int d;
    if (e == 0) return 4'hF;
    d = (e / SD) % 4;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [7:0] exp_seg();
    int d;
    logic [7:0] s;
    if (e == 0) return 8'hFF;
    d = (e / SD) % 4;
    s = HEX[(m_snap >> (4 * d)) & 16'hF];
    if (d == 2) s[7] = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    e = 0; m_snap = 16'h0; m_deb = 1'b0; m_run = 0; m_sq = 2'b00; m_pulse = 1'b0;
  endtask

  task automatic tick();
    logic bs;
    @(posedge CLK);
    if (Reset) begin
      bs      = m_sq[1];
      m_sq    = {m_sq[0], bus.btn_step};
      m_pulse = 1'b0;
      if (bs != m_deb) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_deb   = bs;
          m_run   = 0;
          m_pulse = bs;
        end
      end else begin
        m_run = 0;
      end
      e++;
      if (e == 1 || e % FRAME == 0) m_snap = sel_word();
    end
    cyc++;
    #1;
    check("an", bus.an, exp_an());
    check("seg", bus.seg, exp_seg());
    check("step_pulse", bus.step_pulse, m_pulse);
    if (bus.step_pulse === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
    end
  endtask

  task automatic async_reset(input int hold);
    #2 Reset = 1'b0;
    #1;
    check("rst_an", bus.an, 4'hF);
    check("rst_seg", bus.seg, 8'hFF);
    check("rst_pulse", bus.step_pulse, 1'b0);
    model_reset();
    repeat (hold) tick();
    Reset = 1'b1;
  endtask

  task automatic randomize_inputs();
    bus.in_sign1 = 16'($urandom);
    bus.in_sign2 = 16'($urandom);
    bus.in_sign3 = 16'($urandom);
    bus.in_sign4 = 16'($urandom);
    bus.sw_sel   = 2'($urandom_range(0, 3));
  endtask

  task automatic apply_vec(input vec_t v);
    int k;
    logic [3:0] a;
    logic [7:0] s;
    randomize_inputs();
    bus.sw_sel = v.sel;
    case (v.sel)
      2'd0:    bus.in_sign1 = v.word;
      2'd1:    bus.in_sign2 = v.word;
      2'd2:    bus.in_sign3 = v.word;
      default: bus.in_sign4 = v.word;
    endcase
    k = 0;
    tick();
    while (e % FRAME != 0 && k < FRAME) begin
      tick();
      k++;
    end
    check("frame_align", (e % FRAME == 0), 1'b1);
    for (int d = 0; d < 4; d++) begin
      a = ~(4'b0001 << d);
      case (d)
        0:       s = v.s0;
        1:       s = v.s1;
        2:       s = v.s2;
        default: s = v.s3;
      endcase
      check("vec_an", bus.an, a);
      check("vec_seg", bus.seg, s);
      // Scramble select and data mid-frame; the frame must not tear.
      if (d == 1) randomize_inputs();
      repeat (SD) tick();
    end
  endtask

  initial begin
    vecs[0] = '{2'd0, 16'h1234, 8'h99, 8'hB0, 8'h24, 8'hF9};
    vecs[1] = '{2'd3, 16'hABCD, 8'hA1, 8'hC6, 8'h03, 8'h88};
    vecs[2] = '{2'd1, 16'h0000, 8'hC0, 8'hC0, 8'h40, 8'hC0};
    vecs[3] = '{2'd2, 16'hFFFF, 8'h8E, 8'h8E, 8'h0E, 8'h8E};
    vecs[4] = '{2'd0, 16'h5678, 8'h80, 8'hF8, 8'h02, 8'h92};
    vecs[5] = '{2'd3, 16'h9E0F, 8'h8E, 8'hC0, 8'h06, 8'h90};

    Reset = 1'b0;
    bus.btn_step = 1'b0;
    bus.sw_sel   = 2'd0;
    bus.in_sign1 = 16'h1234;
    bus.in_sign2 = 16'h0;
    bus.in_sign3 = 16'h0;
    bus.in_sign4 = 16'hABCD;
    model_reset();
    pulses = 0;
    last_pulse_cyc = 0;

    tick();
    tick();
    check("reset_an", bus.an, 4'hF);
    check("reset_seg", bus.seg, 8'hFF);
    check("reset_pulse", bus.step_pulse, 1'b0);
    Reset = 1'b1;
    tick();
    check("first_an", bus.an, 4'b1110);
    check("first_seg", bus.seg, 8'h99);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Clean press/release: one pulse, one cycle wide, after sync + debounce.
    begin
      int c0;
      pulses = 0;
      bus.btn_step = 1'b1;
      c0 = cyc;
      repeat (50) tick();
      bus.btn_step = 1'b0;
      repeat (50) tick();
      check("press_pulses", pulses, 1);
      check("press_latency", ((last_pulse_cyc - c0) >= 9 && (last_pulse_cyc - c0) <= 11), 1'b1);
    end

    // Short bounces never qualify.
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      bus.btn_step = ((i / 3) % 2 == 0);
      tick();
    end
    bus.btn_step = 1'b0;
    repeat (20) tick();
    check("bounce_pulses", pulses, 0);

    // Low glitch while held gives no second pulse; a clean re-press does.
    pulses = 0;
    bus.btn_step = 1'b1; repeat (30) tick();
    bus.btn_step = 1'b0; repeat (3) tick();
    bus.btn_step = 1'b1; repeat (30) tick();
    check("glitch_pulses", pulses, 1);
    bus.btn_step = 1'b0; repeat (30) tick();
    bus.btn_step = 1'b1; repeat (30) tick();
    check("repress_pulses", pulses, 2);
    bus.btn_step = 1'b0; repeat (30) tick();

    // Reset mid-debounce and mid-frame; button still held afterwards.
    bus.sw_sel   = 2'd2;
    bus.in_sign3 = 16'h5A3E;
    bus.btn_step = 1'b1;
    repeat (8) tick();
    async_reset(3);
    pulses = 0;
    tick();
    check("rerst_an", bus.an, 4'b1110);
    check("rerst_seg", bus.seg, 8'h86);
    repeat (30) tick();
    check("held_after_reset_pulses", pulses, 1);
    bus.btn_step = 1'b0;
    repeat (20) tick();

    // Randomized run with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) bus.btn_step = ~bus.btn_step;
      if ($urandom_range(0, 9) == 0) randomize_inputs();
      if ($urandom_range(0, 499) == 0) async_reset(2);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
